// File: rtl/debug_run_controller_if.sv
// Command, register-read and transmit signals between the debug run
// controller (master) and the core/host environment (slave).
interface debug_run_controller_if #(
    parameter int DATA_W = 32
) ();
    logic              Cmd_Valid;
    logic [2:0]        Cmd_Code;
    logic              Cmd_Ready;
    logic              Halt_Detected;
    logic              Pipe_Enable;
    logic              Dbg_RegSel;
    logic [4:0]        Dbg_RegAddr;
    logic [DATA_W-1:0] Reg_Data;
    logic [DATA_W-1:0] Tx_Data;
    logic              Tx_Valid;
    logic              Tx_Ready;
    logic              Halted;
    logic [31:0]       Cycle_Count;

    // Controller side
    modport master (
        input  Cmd_Valid, Cmd_Code, Halt_Detected, Reg_Data, Tx_Ready,
        output Cmd_Ready, Pipe_Enable, Dbg_RegSel, Dbg_RegAddr,
               Tx_Data, Tx_Valid, Halted, Cycle_Count
    );

    // Core / host side
    modport slave (
        output Cmd_Valid, Cmd_Code, Halt_Detected, Reg_Data, Tx_Ready,
        input  Cmd_Ready, Pipe_Enable, Dbg_RegSel, Dbg_RegAddr,
               Tx_Data, Tx_Valid, Halted, Cycle_Count
    );
endinterface

// File: rtl/debug_run_controller.sv
// Debug sequencer for the pipelined MIPS core: gates pipeline advance for
// run/step/halt, and streams all registers plus the cycle counter to the
// transmitter by borrowing the register-file rs read port.
module debug_run_controller #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic Clock,
    input  logic Reset,
    debug_run_controller_if.master bus
);
    localparam logic [2:0] CMD_RUN  = 3'b001;
    localparam logic [2:0] CMD_STEP = 3'b010;
    localparam logic [2:0] CMD_HALT = 3'b011;
    localparam logic [2:0] CMD_DUMP = 3'b100;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, RUN, STEP, HALTED, DUMP_READ, DUMP_SEND, DUMP_CNT
    } stateT;

    stateT             stateReg;
    stateT             retReg;
    logic [4:0]        idxReg;
    logic [DATA_W-1:0] txDataReg;
    logic              txValidReg;
    logic [31:0]       cycleCountReg;

    logic pipeEnable;
    logic cmdReady;
    logic cmdAccept;
    logic inDump;

    // Pipeline gating must react to Halt_Detected in the same cycle, so it
    // is decoded combinationally from the state register.
    always_comb begin
        pipeEnable = ((stateReg == RUN) || (stateReg == STEP)) && !bus.Halt_Detected;
        cmdReady   = (stateReg == IDLE) || (stateReg == RUN) || (stateReg == HALTED);
        cmdAccept  = bus.Cmd_Valid && cmdReady;
        inDump     = (stateReg == DUMP_READ) || (stateReg == DUMP_SEND) || (stateReg == DUMP_CNT);
    end

    // Sequencer, dump engine and cycle counter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stateReg      <= IDLE;
            retReg        <= IDLE;
            idxReg        <= '0;
            txDataReg     <= '0;
            txValidReg    <= 1'b0;
            cycleCountReg <= '0;
        end else begin
            if (pipeEnable) begin
                cycleCountReg <= cycleCountReg + 32'd1;
            end
            case (stateReg)
                IDLE: begin
                    if (cmdAccept) begin
                        case (bus.Cmd_Code)
                            CMD_RUN:  stateReg <= RUN;
                            CMD_STEP: stateReg <= STEP;
                            CMD_DUMP: begin
                                stateReg <= DUMP_READ;
                                retReg   <= IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // A halt reaching write-back wins over a HALT command.
                    if (bus.Halt_Detected) begin
                        stateReg <= HALTED;
                    end else if (cmdAccept && (bus.Cmd_Code == CMD_HALT)) begin
                        stateReg <= IDLE;
                    end
                end
                STEP: begin
                    stateReg <= bus.Halt_Detected ? HALTED : IDLE;
                end
                HALTED: begin
                    if (cmdAccept && (bus.Cmd_Code == CMD_DUMP)) begin
                        stateReg <= DUMP_READ;
                        retReg   <= HALTED;
                    end
                end
                DUMP_READ: begin
                    txDataReg  <= bus.Reg_Data;
                    txValidReg <= 1'b1;
                    stateReg   <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (bus.Tx_Ready) begin
                        if (idxReg == LAST_IDX) begin
                            // Counter word follows the last register back to back.
                            txDataReg  <= DATA_W'(cycleCountReg);
                            txValidReg <= 1'b1;
                            stateReg   <= DUMP_CNT;
                        end else begin
                            txValidReg <= 1'b0;
                            idxReg     <= idxReg + 5'd1;
                            stateReg   <= DUMP_READ;
                        end
                    end
                end
                DUMP_CNT: begin
                    if (bus.Tx_Ready) begin
                        txValidReg <= 1'b0;
                        idxReg     <= '0;
                        stateReg   <= retReg;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign bus.Pipe_Enable = pipeEnable;
    assign bus.Cmd_Ready   = cmdReady;
    assign bus.Dbg_RegSel  = (stateReg == DUMP_READ) || (stateReg == DUMP_SEND);
    assign bus.Dbg_RegAddr = idxReg;
    assign bus.Tx_Data     = txDataReg;
    assign bus.Tx_Valid    = txValidReg;
    assign bus.Halted      = (stateReg == HALTED) || (inDump && (retReg == HALTED));
    assign bus.Cycle_Count = cycleCountReg;

endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: directed command sequences, with dump
// words checked by a queue-based scoreboard in a separate monitor.
module tb_debug_run_controller;
    localparam logic [2:0] C_RUN  = 3'b001;
    localparam logic [2:0] C_STEP = 3'b010;
    localparam logic [2:0] C_HALT = 3'b011;
    localparam logic [2:0] C_DUMP = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] expQ[$];
    bit          sbEnable = 1'b0;
    int          readyMode = 1;   // 0: hold 0, 1: hold 1, 2: toggle every 3 cycles
    int          pipeCnt = 0;
    int          wordCnt = 0;

    debug_run_controller_if #(.DATA_W(32)) ifc ();

    debug_run_controller #(.NUM_REGS(32), .DATA_W(32)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Register file model: each register holds its index times 0x11.
    assign ifc.Reg_Data = {27'd0, ifc.Dbg_RegAddr} * 32'h11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command (called just after a rising edge) and hold it until accepted.
    task automatic sendCmd(input logic [2:0] code);
        int n;
        ifc.Cmd_Valid = 1'b1;
        ifc.Cmd_Code  = code;
        n = 0;
        @(negedge clk);
        while (!ifc.Cmd_Ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.Cmd_Ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        tick();
        ifc.Cmd_Valid = 1'b0;
        ifc.Cmd_Code  = 3'b000;
    endtask

    // Transmit-ready driver.
    int tgl = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: ifc.Tx_Ready = 1'b0;
            1: ifc.Tx_Ready = 1'b1;
            default: begin
                tgl++;
                if (tgl >= 3) begin
                    tgl = 0;
                    ifc.Tx_Ready = ~ifc.Tx_Ready;
                end
            end
        endcase
    end

    // Count cycles with Pipe_Enable high.
    always @(negedge clk) begin
        if (ifc.Pipe_Enable === 1'b1) pipeCnt++;
    end

    // Scoreboard monitor: each handshake pops one expected word; a stalled
    // word must keep its value.
    logic [31:0] stallData;
    bit          stallValid = 1'b0;
    always @(negedge clk) begin
        if (sbEnable) begin
            if (ifc.Tx_Valid === 1'b1 && ifc.Tx_Ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %0h expected none", ifc.Tx_Data);
                end else begin
                    check($sformatf("tx_word%0d", wordCnt), ifc.Tx_Data, expQ.pop_front());
                end
                wordCnt++;
                stallValid = 1'b0;
            end else if (ifc.Tx_Valid === 1'b1) begin
                if (stallValid) check("tx_stable", ifc.Tx_Data, stallData);
                stallValid = 1'b1;
                stallData  = ifc.Tx_Data;
            end else begin
                stallValid = 1'b0;
            end
        end else begin
            stallValid = 1'b0;
        end
    end

    // Run a dump with the expected stream queued; returns the busy cycle count.
    task automatic doDump(input logic [31:0] cnt, output int cycles);
        int base;
        for (int i = 0; i < 32; i++) expQ.push_back(32'(i) * 32'h11);
        expQ.push_back(cnt);
        wordCnt  = 0;
        sbEnable = 1'b1;
        base     = pipeCnt;
        sendCmd(C_DUMP);
        cycles = 0;
        @(negedge clk);
        while (!ifc.Cmd_Ready && cycles < 1000) begin
            cycles++;
            if (ifc.Halted !== 1'b1) check("dump_halted_held", {31'd0, ifc.Halted}, 32'd1);
            @(negedge clk);
        end
        if (cycles >= 1000) check("dump_timeout", 32'd0, 32'd1);
        sbEnable = 1'b0;
        check("dump_pipe_frozen", 32'(pipeCnt - base), 32'd0);
        check("dump_words", 32'(wordCnt), 32'd33);
        check("dump_queue_empty", 32'(expQ.size()), 32'd0);
        expQ.delete();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        int n;
        ifc.Cmd_Valid     = 1'b0;
        ifc.Cmd_Code      = 3'b000;
        ifc.Halt_Detected = 1'b0;
        ifc.Tx_Ready      = 1'b1;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pipe_enable", {31'd0, ifc.Pipe_Enable}, 32'd0);
        check("rst_cmd_ready",   {31'd0, ifc.Cmd_Ready},   32'd1);
        check("rst_regsel",      {31'd0, ifc.Dbg_RegSel},  32'd0);
        check("rst_regaddr",     {27'd0, ifc.Dbg_RegAddr}, 32'd0);
        check("rst_tx_data",     ifc.Tx_Data,              32'd0);
        check("rst_tx_valid",    {31'd0, ifc.Tx_Valid},    32'd0);
        check("rst_halted",      {31'd0, ifc.Halted},      32'd0);
        check("rst_cycle_count", ifc.Cycle_Count,          32'd0);
        tick();
        rst = 1'b0;
        tick();

        // STEP x3
        base = pipeCnt;
        for (int s = 0; s < 3; s++) begin
            sendCmd(C_STEP);
            tick();
            tick();
        end
        @(negedge clk);
        check("step_pipe_cycles", 32'(pipeCnt - base), 32'd3);
        check("step_cycle_count", ifc.Cycle_Count, 32'd3);
        check("step_idle_ready",  {31'd0, ifc.Cmd_Ready}, 32'd1);
        check("step_pipe_low",    {31'd0, ifc.Pipe_Enable}, 32'd0);
        tick();

        // RUN 10 cycles then HALT command
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        base = pipeCnt;
        sendCmd(C_RUN);
        repeat (9) tick();
        sendCmd(C_HALT);
        @(negedge clk);
        check("run_pipe_after_halt", {31'd0, ifc.Pipe_Enable}, 32'd0);
        tick();
        @(negedge clk);
        check("run_pipe_cycles",  32'(pipeCnt - base), 32'd10);
        check("run_cycle_count",  ifc.Cycle_Count, 32'd10);
        check("run_halted",       {31'd0, ifc.Halted}, 32'd0);
        tick();

        // RUN, Halt_Detected with a HALT command in cycle 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        base = pipeCnt;
        sendCmd(C_RUN);
        repeat (4) tick();
        ifc.Halt_Detected = 1'b1;
        ifc.Cmd_Valid     = 1'b1;
        ifc.Cmd_Code      = C_HALT;
        @(negedge clk);
        check("halt_comb_stop", {31'd0, ifc.Pipe_Enable}, 32'd0);
        tick();
        ifc.Halt_Detected = 1'b0;
        ifc.Cmd_Valid     = 1'b0;
        @(negedge clk);
        check("halt_pipe_cycles", 32'(pipeCnt - base), 32'd4);
        check("halt_halted",      {31'd0, ifc.Halted}, 32'd1);
        check("halt_cycle_count", ifc.Cycle_Count, 32'd4);
        tick();
        sendCmd(C_RUN);
        sendCmd(C_STEP);
        repeat (3) tick();
        @(negedge clk);
        check("halt_ignores_cmds", 32'(pipeCnt - base), 32'd4);
        check("halt_still_halted", {31'd0, ifc.Halted}, 32'd1);
        tick();

        // Dump from HALTED with Tx_Ready held high
        readyMode = 1;
        tick();
        doDump(32'd4, cyc);
        check("dump_cycles", 32'(cyc), 32'd65);
        @(negedge clk);
        check("dump_return_halted", {31'd0, ifc.Halted}, 32'd1);
        tick();

        // Dump with Tx_Ready toggling every 3 cycles
        readyMode = 2;
        doDump(32'd4, cyc);
        readyMode = 1;
        @(negedge clk);
        check("dump2_return_halted", {31'd0, ifc.Halted}, 32'd1);
        tick();

        // Reset in DUMP_SEND at index 7
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sendCmd(C_STEP);
        tick();
        sendCmd(C_STEP);
        tick();
        sendCmd(C_DUMP);
        n = 0;
        @(negedge clk);
        while (!(ifc.Dbg_RegAddr == 5'd7 && ifc.Tx_Valid === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rdump_reached_idx7", {27'd0, ifc.Dbg_RegAddr}, 32'd7);
        check("rdump_count_before", ifc.Cycle_Count, 32'd2);
        rst = 1'b1;
        #1;
        check("rdump_tx_valid", {31'd0, ifc.Tx_Valid},   32'd0);
        check("rdump_regsel",   {31'd0, ifc.Dbg_RegSel}, 32'd0);
        check("rdump_count",    ifc.Cycle_Count,         32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rdump_idle_ready", {31'd0, ifc.Cmd_Ready},   32'd1);
        check("rdump_pipe_low",   {31'd0, ifc.Pipe_Enable}, 32'd0);
        check("rdump_halted",     {31'd0, ifc.Halted},      32'd0);
        tick();
        sendCmd(C_STEP);
        tick();
        @(negedge clk);
        check("rdump_step_count", ifc.Cycle_Count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Sequencer for the pipelined MIPS core under debug control. Accepts run/step/halt/dump commands, gates the pipeline advance enable (ANDed into PCWrite, IFIDWrite and all stage-register writes), and borrows the ID-stage register-file rs read port to stream every register plus a cycle counter out to the transmit side.

## Interface
- NUM_REGS, 32: registers dumped, indices 0..NUM_REGS-1, max 32.
- DATA_W, 32: register and transmit word width.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Cmd_Valid  in  1  command present.
- Cmd_Code  in  3  001 RUN, 010 STEP, 011 HALT, 100 DUMP; other codes are consumed with no effect.
- Cmd_Ready  out  1  controller accepts a command this cycle.
- Halt_Detected  in  1  HALT instruction reached write-back this cycle.
- Pipe_Enable  out  1  pipeline may advance this cycle.
- Dbg_RegSel  out  1  steers the register-file rs read address to Dbg_RegAddr.
- Dbg_RegAddr  out  5  debug read address.
- Reg_Data  in  DATA_W  register-file ReadData1, combinational from the address.
- Tx_Data  out  DATA_W  word to send; registered.
- Tx_Valid  out  1  Tx_Data valid; registered.
- Tx_Ready  in  1  transmitter accepts the word.
- Halted  out  1  program has finished.
- Cycle_Count  out  32  count of cycles with Pipe_Enable=1.

## Operation
- States: IDLE, RUN, STEP, HALTED, DUMP_READ, DUMP_SEND, DUMP_CNT.
- Command accept = Cmd_Valid & Cmd_Ready.
- Cmd_Ready is 1 in IDLE, RUN and HALTED. It is 0 in STEP and all DUMP_* states.
- IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - DUMP → DUMP_READ, with ret=IDLE.
  - HALT: no effect.
- RUN:
  - Pipe_Enable = ~Halt_Detected.
  - Halt_Detected → HALTED, otherwise HALT cmd → IDLE.
  - Halt_Detected takes precedence over a simultaneous HALT command.
  - RUN, STEP and DUMP commands are consumed and ignored.
- STEP:
  - Pipe_Enable = ~Halt_Detected for exactly one cycle.
  - Next state is HALTED if Halt_Detected, else IDLE.
- HALTED:
  - Halted=1.
  - DUMP → DUMP_READ, with ret=HALTED.
  - RUN, STEP and HALT are ignored.
  - Leaving HALTED requires Reset.
- DUMP_READ: Dbg_RegSel=1, Dbg_RegAddr=idx. At the edge: Tx_Data←Reg_Data, Tx_Valid←1, go to DUMP_SEND.
- DUMP_SEND:
  - Dbg_RegSel=1, address held.
  - On Tx_Valid & Tx_Ready: Tx_Valid←0.
  - If idx=NUM_REGS-1, go to DUMP_CNT with Tx_Data←Cycle_Count, Tx_Valid←1; otherwise idx←idx+1 and go to DUMP_READ.
- DUMP_CNT: on Tx_Ready, Tx_Valid←0, idx←0, go to ret.
- Pipe_Enable is 0 in every state except RUN and STEP, so the pipeline is frozen during a dump.
- Cycle_Count increments when Pipe_Enable=1 and wraps from 0xFFFFFFFF to 0. It is cleared only by Reset.
- Halted is 1 exactly in HALTED. It also stays 1 during a dump entered from HALTED, i.e. ret=HALTED.

## Timing
- Reset values:
  - state IDLE, idx 0, ret IDLE.
  - Pipe_Enable 0, Cmd_Ready 1, Dbg_RegSel 0, Dbg_RegAddr 0.
  - Tx_Data 0, Tx_Valid 0, Halted 0, Cycle_Count 0.
- Reset asserted mid-dump drops Tx_Valid asynchronously, with no completion of the current word.
- Command latency: accepted at edge N, the new state's outputs are visible in cycle N+1. RUN accepted at edge N gives Pipe_Enable=1 from cycle N+1.
- Halt stop is combinational: Pipe_Enable is 0 in the same cycle Halt_Detected=1, and in all later cycles.
- Dump timing:
  - Minimum 2 cycles per register word with Tx_Ready held at 1.
  - Total 2·NUM_REGS+1 cycles from the first DUMP_READ to return.
  - Tx_Valid is never deasserted without a handshake.
  - Tx_Data is stable while Tx_Valid=1 & Tx_Ready=0.
- Tx_Ready while Tx_Valid=0 is ignored.
- Cmd_Valid while Cmd_Ready=0 is not consumed; the source holds it.

## Test plan
- Reset, then STEP ×3 (Halt_Detected=0) → Pipe_Enable high for exactly 3 single cycles; Cycle_Count=3; state IDLE.
- RUN, hold 10 cycles, then HALT cmd → Pipe_Enable high 10 cycles then 0 from the cycle after accept; Cycle_Count=10; Halted=0.
- RUN, Halt_Detected=1 on cycle 5 together with a HALT cmd → Pipe_Enable 1 for cycles 1–4 and 0 in cycle 5; Halted=1; subsequent RUN and STEP are ignored.
- From HALTED, DUMP with Reg_Data=addr·0x11, Tx_Ready=1 → 33 words: 0x00, 0x11, …, 0x1F·0x11, then Cycle_Count; returns to HALTED after 65 cycles.
- DUMP with Tx_Ready toggling 0/1 every 3 cycles → no word lost or duplicated; Tx_Data stable while stalled; Pipe_Enable stays 0 throughout.
- Reset asserted during DUMP_SEND (idx=7) → Tx_Valid, Dbg_RegSel and Cycle_Count are 0 immediately; state IDLE after release.
